// File: rtl/inst_prefetch_queue_pkg.sv
// Shared fetch types for the instruction prefetch queue.
// Types holds the raw word types; FetchType holds FSM and entry types.
package Types;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] inst_t;
endpackage

package FetchType;
  import Types::*;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    addr_t pc;
    inst_t inst;
  } fetch_entry_t;

  localparam addr_t INST_BYTES = 32'd4;

  function automatic addr_t align_pc(input addr_t a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/inst_prefetch_queue_fifo.sv
// Circular buffer of fetched {pc, inst} entries.
// Flush empties the queue and outranks push and pop.
module inst_fifo
  import Types::*;
  import FetchType::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + 1'b1;
      if (pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(push)
                         - (AW+1)'(pop);
    end
  end

  // Entry storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst)
      r_mem[r_wptr] <= wdata;
  end

  assign rdata = r_mem[r_rptr];
  assign count = r_count;
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: fetch FSM, fetch_pc and an entry FIFO.
// Optional macro FETCH_BYPASS_EN forwards a response into an empty queue.
module inst_prefetch_queue
  import Types::*;
  import FetchType::*;
#(
  parameter addr_t       RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  redirect,
  input  addr_t redirect_pc,
  output logic  mem_req_valid,
  output addr_t mem_req_addr,
  input  logic  mem_req_ready,
  input  logic  mem_resp_valid,
  input  inst_t mem_resp_data,
  output logic  inst_valid,
  output inst_t inst,
  output addr_t inst_pc,
  input  logic  inst_ready
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  addr_t        r_fetch_pc;
  addr_t        w_pc_nxt;

  logic         w_resp_take;
  logic         w_bypass;
  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  logic [AW:0]  w_count;
  fetch_entry_t w_wdata;
  fetch_entry_t w_rdata;

  // State and fetch address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= REQ;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_pc_nxt;
    end
  end

  // Next state, fetch_pc update and memory request.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_fetch_pc;
    w_resp_take   = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = r_fetch_pc;
    unique case (r_state)
      REQ: begin
        mem_req_valid = !w_full && !redirect && !rst;
        if (redirect)
          w_pc_nxt = align_pc(redirect_pc);
        else if (mem_req_valid && mem_req_ready)
          w_state_nxt = WAIT;
      end
      WAIT: begin
        if (redirect) begin
          w_pc_nxt    = align_pc(redirect_pc);
          w_state_nxt = mem_resp_valid ? REQ : DISCARD;
        end else if (mem_resp_valid) begin
          w_resp_take = !rst;
          w_pc_nxt    = r_fetch_pc + INST_BYTES;
          w_state_nxt = REQ;
        end
      end
      DISCARD: begin
        if (redirect)
          w_pc_nxt = align_pc(redirect_pc);
        if (mem_resp_valid)
          w_state_nxt = REQ;
      end
      default: w_state_nxt = REQ;
    endcase
  end

  // Consumer side: head selection, optional bypass, push and pop.
  always_comb begin
    w_wdata    = '{pc: r_fetch_pc, inst: mem_resp_data};
    inst_valid = (w_count != '0) && !redirect && !rst;
    inst       = w_rdata.inst;
    inst_pc    = w_rdata.pc;
    w_bypass   = 1'b0;
`ifdef FETCH_BYPASS_EN
    w_bypass = w_resp_take && w_empty;
    if (w_bypass) begin
      inst_valid = 1'b1;
      inst       = mem_resp_data;
      inst_pc    = r_fetch_pc;
    end
`endif
    w_pop  = inst_valid && inst_ready && !w_empty;
    w_push = w_resp_take && !(w_bypass && inst_ready);
  end

  inst_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect),
    .wdata (w_wdata),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: directed steps, then random traffic.
// Reference model tracks occupancy and expected address streams only.
module tb_inst_prefetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  always #5 clk = ~clk;

  inst_prefetch_queue #(
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  bit          pend;
  bit          live;
  bit          spur_en;
  int          wl;
  int          lat;
  int          occ;
  logic [31:0] pend_addr;
  logic [31:0] exp_addr;
  logic [31:0] exp_cons;
  bit          last_rv;
  logic [31:0] req_log[$];
  logic [31:0] cons_log[$];

  function automatic logic [31:0] hash(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$],
                                      input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] want);
    total++;
    assert (obs === want) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic cycle(input bit rs, input bit rdy, input bit irdy,
                       input bit redir, input logic [31:0] rpc);
    bit fire, ev_rv, ev_iv, hon, acc, pop;
    rst         = rs;
    mem_req_ready = rdy;
    inst_ready  = irdy;
    redirect    = redir;
    redirect_pc = rpc;
    fire = pend && (wl == 0);
    mem_resp_valid = fire ||
      (!pend && spur_en && ($urandom_range(0, 7) == 0));
    mem_resp_data = fire ? hash(pend_addr) : $urandom;
    #1;
    last_rv = mem_req_valid;
    if (rs) begin
      chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      pend = 0; live = 0; occ = 0;
      exp_addr = RST_PC;
      exp_cons = RST_PC;
    end else begin
      hon   = fire && live && !redir;
      ev_rv = !pend && (occ < DEPTH) && !redir;
      ev_iv = (occ > 0) && !redir;
`ifdef FETCH_BYPASS_EN
      if (occ == 0 && hon) ev_iv = 1;
`endif
      chk("req_valid", 32'(mem_req_valid), 32'(ev_rv));
      if (ev_rv && mem_req_valid)
        chk("req_addr", mem_req_addr, exp_addr);
      chk("inst_valid", 32'(inst_valid), 32'(ev_iv));
      acc = ev_rv && rdy;
      pop = ev_iv && irdy;
      if (pop && inst_valid) begin
        chk("inst_pc", inst_pc, exp_cons);
        chk("inst_data", inst, hash(inst_pc));
        cons_log.push_back(inst_pc);
      end
      if (pop) exp_cons += 32'd4;
      if (redir) begin
        occ = 0; live = 0;
        exp_addr = {rpc[31:2], 2'b00};
        exp_cons = {rpc[31:2], 2'b00};
      end else begin
        occ = occ + int'(hon) - int'(pop);
      end
      if (fire) pend = 0;
      if (acc) begin
        pend = 1; live = 1; wl = lat - 1;
        pend_addr = mem_req_addr;
        exp_addr += 32'd4;
        req_log.push_back(mem_req_addr);
      end else if (pend && wl > 0) begin
        wl--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit r, d;
    rst = 1; redirect = 0; redirect_pc = '0;
    mem_req_ready = 0; mem_resp_valid = 0;
    mem_resp_data = '0; inst_ready = 0;
    pend = 0; live = 0; spur_en = 0; wl = 0;
    lat = 1; occ = 0;
    exp_addr = RST_PC; exp_cons = RST_PC;
    pend_addr = '0;

    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0);

    req_log.delete(); cons_log.delete();
    repeat (12) cycle(0, 1, 1, 0, 0);
    chk("seq_req0", qat(req_log, 0), 32'h0);
    chk("seq_req1", qat(req_log, 1), 32'h4);
    chk("seq_req2", qat(req_log, 2), 32'h8);
    chk("seq_pc0", qat(cons_log, 0), 32'h0);
    chk("seq_pc1", qat(cons_log, 1), 32'h4);
    chk("seq_pc2", qat(cons_log, 2), 32'h8);

    cycle(0, 1, 1, 1, 32'h40);
    req_log.delete();
    repeat (14) cycle(0, 1, 0, 0, 0);
    chk("full_reqs", 32'(req_log.size()), 32'd4);
    cycle(0, 1, 1, 0, 0);
    chk("full_hold", 32'(last_rv), 32'd0);
    cycle(0, 1, 0, 0, 0);
    chk("after_pop_req", 32'(last_rv), 32'd1);
    chk("fifth_addr", qat(req_log, 4), 32'h50);

    lat = 3;
    cycle(0, 1, 1, 1, 32'h80);
    for (int i = 0; i < 8 && !pend; i++) cycle(0, 1, 1, 0, 0);
    chk("wait_accept", 32'(pend), 32'd1);
    cycle(0, 0, 1, 1, 32'h100);
    req_log.delete(); cons_log.delete();
    repeat (10) cycle(0, 1, 1, 0, 0);
    chk("redir_req", qat(req_log, 0), 32'h100);
    chk("redir_pc", qat(cons_log, 0), 32'h100);

    lat = 2;
    cycle(0, 1, 1, 1, 32'h180);
    for (int i = 0; i < 8 && !pend; i++) cycle(0, 1, 1, 0, 0);
    for (int i = 0; i < 8 && !(pend && wl == 0); i++)
      cycle(0, 0, 1, 0, 0);
    chk("coinc_due", 32'(pend && wl == 0), 32'd1);
    req_log.delete();
    cycle(0, 1, 1, 1, 32'h203);
    cycle(0, 1, 1, 0, 0);
    chk("coinc_t1_req", 32'(last_rv), 32'd1);
    repeat (3) cycle(0, 1, 1, 0, 0);
    chk("coinc_addr", qat(req_log, 0), 32'h200);

    lat = 1;
    cycle(0, 1, 1, 1, 32'hFFFF_FFF8);
    req_log.delete(); cons_log.delete();
    repeat (12) cycle(0, 1, 1, 0, 0);
    chk("wrap_req0", qat(req_log, 0), 32'hFFFF_FFF8);
    chk("wrap_req1", qat(req_log, 1), 32'hFFFF_FFFC);
    chk("wrap_req2", qat(req_log, 2), 32'h0000_0000);
    chk("wrap_pc2", qat(cons_log, 2), 32'h0000_0000);

    spur_en = 1;
    for (int i = 0; i < 1500; i++) begin
      lat = $urandom_range(1, 3);
      r = ($urandom_range(0, 299) == 0);
      d = !r && ($urandom_range(0, 19) == 0);
      cycle(r, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, d, $urandom);
    end
    spur_en = 0;
    cycle(1, 1, 1, 0, 0);
    repeat (6) cycle(0, 1, 1, 0, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/inst_prefetch_queue.md
INST_PREFETCH_QUEUE -- requirements
Module: inst_prefetch_queue

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter DEPTH, default 4, is the queue entry count; it SHALL be a power of two and at least 2.
REQ-003 Port clk, input, 1 bit: the single clock.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port redirect, input, 1 bit: flush the queue and restart fetch at redirect_pc.
REQ-006 Port redirect_pc, input, 32 bits (addr_t): new fetch address.
REQ-007 Port mem_req_valid, output, 1 bit: instruction-memory read request.
REQ-008 Port mem_req_addr, output, 32 bits: request address.
REQ-009 Port mem_req_ready, input, 1 bit: memory accepts the request.
REQ-010 Port mem_resp_valid, input, 1 bit: read data valid; responses return in order.
REQ-011 Port mem_resp_data, input, 32 bits (inst_t): fetched word.
REQ-012 Port inst_valid, output, 1 bit: queue head is valid.
REQ-013 Port inst, output, 32 bits: head instruction.
REQ-014 Port inst_pc, output, 32 bits: head instruction address.
REQ-015 Port inst_ready, input, 1 bit: the consumer takes the head.

Function
REQ-016 The FSM SHALL have three states: REQ, WAIT and DISCARD, with at most one memory request outstanding.
REQ-017 In REQ, mem_req_valid = (count < DEPTH) && !redirect, and mem_req_addr = fetch_pc.
REQ-018 REQ SHALL go to WAIT on mem_req_valid && mem_req_ready.
REQ-019 In WAIT, mem_resp_valid with no redirect SHALL push {fetch_pc, mem_resp_data}, advance fetch_pc by 4, and return to REQ.
REQ-020 fetch_pc SHALL wrap modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-021 In REQ, redirect SHALL flush the queue (count = 0), load fetch_pc = {redirect_pc[31:2], 2'b00} and stay in REQ.
REQ-022 In WAIT, redirect without mem_resp_valid SHALL flush, load fetch_pc and go to DISCARD.
REQ-023 In WAIT, redirect together with mem_resp_valid SHALL drop the response, flush, load fetch_pc and go to REQ.
REQ-024 In DISCARD, the next mem_resp_valid SHALL be dropped and the FSM SHALL go to REQ.
REQ-025 In DISCARD, a further redirect SHALL reload fetch_pc and flush while staying in DISCARD.
REQ-026 In REQ, mem_resp_valid SHALL be ignored.
REQ-027 inst_valid = (count != 0) && !redirect; a pop SHALL occur on inst_valid && inst_ready.
REQ-028 On a redirect cycle the flush SHALL have priority and no pop SHALL occur.
REQ-029 Push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-030 The queue SHALL never overflow, because a request is issued only when count < DEPTH and count cannot grow while a request is outstanding.
REQ-031 Latency: a response at cycle t SHALL appear on inst/inst_valid at t+1.
REQ-032 Latency: a redirect at cycle t SHALL give mem_req_valid with the new address at t+1 when the FSM is in REQ.
REQ-033 The queue SHALL be a circular buffer whose read and write pointers wrap modulo DEPTH.

Reset
REQ-034 When rst = 1 at a clock edge: state = REQ, fetch_pc = RESET_PC, count = 0, and both pointers = 0.
REQ-035 mem_req_valid and inst_valid SHALL be 0 during any cycle in which rst is high.
REQ-036 A reset taken in WAIT or DISCARD SHALL abandon the outstanding request; because the instruction memory shares rst, no stale response is honoured.

Configuration
REQ-037 Macro FETCH_BYPASS_EN, when defined, SHALL forward a response pushed into an empty queue combinationally onto inst, inst_pc and inst_valid in the same cycle (latency 0).
REQ-038 With FETCH_BYPASS_EN defined, a bypassed word accepted by inst_ready in that cycle SHALL NOT be written into the queue.
REQ-039 Without FETCH_BYPASS_EN, all outputs SHALL come from registered queue state, with the latency given in REQ-031.

Structure
REQ-040 Package FetchType SHALL hold fetch_state_t (REQ, WAIT, DISCARD) and the fetch_entry_t struct {addr_t pc; inst_t inst;}; addr_t and inst_t SHALL come from Types.
REQ-041 The storage SHALL be one sub-module, inst_fifo, parameterised by DEPTH, with push/pop/flush inputs and full/empty/count outputs; the FSM and fetch_pc SHALL stay in the top module.

Verification
REQ-042 Reset, then memory ready with a 1-cycle response -> requests to 0x0, 0x4, 0x8 in order; inst_pc sequence 0x0, 0x4, 0x8 with the matching data.
REQ-043 inst_ready = 0 with DEPTH = 4 -> exactly 4 requests; mem_req_valid held at 0 while count = 4; the 5th request issues the cycle after the first pop.
REQ-044 Redirect to 0x100 in WAIT, response 2 cycles later -> response dropped, inst_valid = 0, next request is to 0x100, first inst_pc = 0x100.
REQ-045 Redirect to 0x203 in the same cycle as mem_resp_valid -> response dropped, next mem_req_addr = 0x200, state REQ.
REQ-046 RESET_PC = 0xFFFF_FFF8 -> request sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
REQ-047 Build with FETCH_BYPASS_EN and inst_ready = 1, queue empty -> inst_valid rises in the same cycle as mem_resp_valid and count stays 0.
